// File: rtl/ucsbece154a_run_checker.sv
// Run-and-check harness for the multicycle RISC-V top: resets and runs the
// processor, then compares NCHK observed values against expected values.
module ucsbece154a_run_checker #(
    parameter int NCHK         = 8,
    parameter int RESET_CYCLES = 1,
    parameter int RUN_CYCLES   = 100,
    parameter int HALT_CYCLES  = 16,
    parameter int MAX_CYCLES   = 1000,
    localparam int IW          = (NCHK > 1) ? $clog2(NCHK) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_i,
    input  logic              mode_i,
    input  logic [31:0]       pc_i,
    input  logic [32*NCHK-1:0] obs_i,
    input  logic [32*NCHK-1:0] exp_i,
    input  logic [NCHK-1:0]   en_i,
    output logic              proc_reset_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              pass_o,
    output logic              timeout_o,
    output logic [NCHK-1:0]   fail_mask_o,
    output logic [IW-1:0]     first_fail_o,
    output logic [31:0]       cycles_o
);

    typedef enum logic [2:0] {
        IDLE,
        RST,
        RUN,
        CHECK,
        DONE
    } state_t;

    state_t state_q, state_n;

    logic            mode_q, mode_n;
    logic [31:0]     rst_cnt_q, rst_cnt_n;
    logic [31:0]     stable_q, stable_n;
    logic [31:0]     prev_pc_q, prev_pc_n;
    logic [IW-1:0]   idx_q, idx_n;

    logic            proc_reset_n;
    logic            busy_n;
    logic            done_n;
    logic            pass_n;
    logic            timeout_n;
    logic [NCHK-1:0] fail_mask_n;
    logic [IW-1:0]   first_fail_n;
    logic [31:0]     cycles_n;

    logic [31:0]     cyc_inc;
    logic [31:0]     stable_calc;
    logic [31:0]     obs_w [NCHK];
    logic [31:0]     exp_w [NCHK];

    always_comb begin
        for (int k = 0; k < NCHK; k++) begin
            obs_w[k] = obs_i[32*k +: 32];
            exp_w[k] = exp_i[32*k +: 32];
        end
    end

    // Saturating run-cycle increment
    assign cyc_inc = (cycles_o == 32'hFFFF_FFFF) ? cycles_o
                                                 : cycles_o + 32'd1;

    // The first RUN cycle has no previous PC, so it counts as a change
    always_comb begin
        stable_calc = 32'd0;
        if (cycles_o != 32'd0 && pc_i == prev_pc_q)
            stable_calc = stable_q + 32'd1;
    end

    always_comb begin
        state_n      = state_q;
        mode_n       = mode_q;
        rst_cnt_n    = rst_cnt_q;
        stable_n     = stable_q;
        prev_pc_n    = prev_pc_q;
        idx_n        = idx_q;
        proc_reset_n = proc_reset_o;
        busy_n       = busy_o;
        done_n       = done_o;
        pass_n       = pass_o;
        timeout_n    = timeout_o;
        fail_mask_n  = fail_mask_o;
        first_fail_n = first_fail_o;
        cycles_n     = cycles_o;

        unique case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    state_n      = RST;
                    mode_n       = mode_i;
                    rst_cnt_n    = 32'd0;
                    stable_n     = 32'd0;
                    idx_n        = '0;
                    proc_reset_n = 1'b1;
                    busy_n       = 1'b1;
                    done_n       = 1'b0;
                    pass_n       = 1'b0;
                    timeout_n    = 1'b0;
                    fail_mask_n  = '0;
                    first_fail_n = '0;
                    cycles_n     = 32'd0;
                end
            end

            RST: begin
                if (rst_cnt_q == 32'(RESET_CYCLES - 1)) begin
                    state_n      = RUN;
                    rst_cnt_n    = 32'd0;
                    proc_reset_n = 1'b0;
                end else begin
                    rst_cnt_n = rst_cnt_q + 32'd1;
                end
            end

            RUN: begin
                cycles_n  = cyc_inc;
                prev_pc_n = pc_i;
                if (mode_q) begin
                    stable_n = stable_calc;
                    // Halt has priority over a coincident timeout
                    if (stable_calc == 32'(HALT_CYCLES - 1)) begin
                        state_n = CHECK;
                        idx_n   = '0;
                    end else if (cyc_inc == 32'(MAX_CYCLES)) begin
                        state_n   = CHECK;
                        idx_n     = '0;
                        timeout_n = 1'b1;
                    end
                end else if (cyc_inc == 32'(RUN_CYCLES)) begin
                    state_n = CHECK;
                    idx_n   = '0;
                end
            end

            CHECK: begin
                if (en_i[idx_q] && obs_w[idx_q] != exp_w[idx_q]) begin
                    fail_mask_n[idx_q] = 1'b1;
                    if (fail_mask_o == '0)
                        first_fail_n = idx_q;
                end
                if (idx_q == IW'(NCHK - 1)) begin
                    state_n = DONE;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                    pass_n  = (fail_mask_n == '0) && !timeout_o;
                end else begin
                    idx_n = idx_q + IW'(1);
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            mode_q       <= 1'b0;
            rst_cnt_q    <= 32'd0;
            stable_q     <= 32'd0;
            prev_pc_q    <= 32'd0;
            idx_q        <= '0;
            proc_reset_o <= 1'b0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            pass_o       <= 1'b0;
            timeout_o    <= 1'b0;
            fail_mask_o  <= '0;
            first_fail_o <= '0;
            cycles_o     <= 32'd0;
        end else begin
            state_q      <= state_n;
            mode_q       <= mode_n;
            rst_cnt_q    <= rst_cnt_n;
            stable_q     <= stable_n;
            prev_pc_q    <= prev_pc_n;
            idx_q        <= idx_n;
            proc_reset_o <= proc_reset_n;
            busy_o       <= busy_n;
            done_o       <= done_n;
            pass_o       <= pass_n;
            timeout_o    <= timeout_n;
            fail_mask_o  <= fail_mask_n;
            first_fail_o <= first_fail_n;
            cycles_o     <= cycles_n;
        end
    end

endmodule

// File: doc/ucsbece154a_run_checker.md
Name: ucsbece154a_run_checker

Overview:
Synthesizable run-and-check harness for the multicycle RISC-V top. It drives the processor reset and runs the program for a fixed cycle budget or until halt is detected. It then compares NCHK observed architectural values (registers or memory words) against expected values, one channel per cycle, and reports pass/fail. It is the parametrised, self-checking successor of the fixed 100-cycle, hand-asserted end-of-program check.

Parameters:
NCHK, 8, number of check channels (1..64)
RESET_CYCLES, 1, cycles proc_reset_o is held high after start (>=1)
RUN_CYCLES, 100, run length in fixed mode (>=1)
HALT_CYCLES, 16, consecutive cycles with unchanged pc_i that count as halted (>=2)
MAX_CYCLES, 1000, timeout bound in halt-detect mode (>=HALT_CYCLES)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
start_i  in  1  begin a run; honoured only in IDLE and DONE
mode_i  in  1  0 = fixed budget, 1 = halt-detect; sampled with start_i
pc_i  in  32  processor PC
obs_i  in  32*NCHK  observed values; channel k is bits [32k+31:32k]
exp_i  in  32*NCHK  expected values, same packing
en_i  in  NCHK  channel enable; a disabled channel never fails
proc_reset_o  out  1  reset to the processor
busy_o  out  1  high in RST, RUN, CHECK
done_o  out  1  high in DONE
pass_o  out  1  valid when done_o is high
timeout_o  out  1  halt-detect run hit MAX_CYCLES
fail_mask_o  out  NCHK  bit k set if channel k mismatched
first_fail_o  out  max(1,clog2(NCHK))  lowest failing channel index; 0 if none
cycles_o  out  32  cycles spent in RUN

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset, at any time and in any state: state=IDLE; every output 0; all internal counters 0.
- States: IDLE, RST, RUN, CHECK, DONE.
- IDLE/DONE with start_i=1:
  - Latch mode_i.
  - Clear done_o, pass_o, timeout_o, fail_mask_o, first_fail_o, cycles_o.
  - Go to RST.
  - start_i is ignored in all other states.
- RST:
  - proc_reset_o=1 for exactly RESET_CYCLES cycles, then RUN.
  - proc_reset_o is low in every other state.
- RUN:
  - cycles_o increments each cycle, saturating at 0xFFFFFFFF.
  - Fixed mode: leave to CHECK after exactly RUN_CYCLES cycles in RUN.
  - Halt mode: stable counter increments when pc_i equals the previous-cycle pc_i, else it is cleared.
    - The first RUN cycle has no previous PC and counts as a change.
    - Leave to CHECK when stable reaches HALT_CYCLES-1, i.e. HALT_CYCLES equal samples.
  - Halt mode timeout: if cycles_o would reach MAX_CYCLES first, set timeout_o=1 and go to CHECK.
  - Halt and timeout in the same cycle: halt wins and timeout_o stays 0.
- CHECK:
  - Index i runs 0..NCHK-1, one channel per cycle.
  - If en_i[i] && obs_i[i] != exp_i[i]: set fail_mask_o[i]; latch first_fail_o=i if it is the first failure.
  - After i=NCHK-1, go to DONE.
  - obs_i/exp_i are sampled live; the processor is not stalled, so halt mode or stable values are the user's responsibility.
- DONE:
  - done_o=1; pass_o = (fail_mask_o==0) && !timeout_o.
  - Results are held until the next start_i or reset.
- Latency: start edge to done_o high is RESET_CYCLES + RUN cycles + NCHK cycles + 1.
- busy_o is registered and mutually exclusive with done_o.
- Restart from DONE behaves identically to a start from IDLE.

Test Plan:
1. Fixed mode, defaults, all 8 channels equal, en_i=0xFF, pulse start_i -> proc_reset_o high 1 cycle; done_o rises 110 cycles after start; pass_o=1, fail_mask_o=0, cycles_o=100.
2. Fixed mode, channels 2 and 5 mismatch (obs 0x7 vs exp 0xB), all enabled -> fail_mask_o=0x24, first_fail_o=2, pass_o=0.
3. Same as scenario 2 with en_i=0xDB -> fail_mask_o=0, pass_o=1.
4. Halt mode, HALT_CYCLES=16, pc_i increments by 4 for 40 RUN cycles then holds 0x5C -> exit after cycles_o=55; timeout_o=0, pass_o=1.
5. Halt mode, MAX_CYCLES=200, pc_i never stable -> timeout_o=1, cycles_o=200, pass_o=0 even with all channels matching.
6. Assert reset for 1 cycle mid-RUN -> next cycle all outputs 0, IDLE; start_i pulsed during RUN and CHECK of a later run has no effect.
